// File: rtl/rs_issue_select.sv
// rs_issue_select_pkg: issue packet layout shared by the RS entries, the
// select stage and the FU pipelines.
package rs_issue_select_pkg;
  localparam int unsigned PRF_WIDTH = 6;
  localparam int unsigned PC_WIDTH  = 32;
  localparam int unsigned OP_WIDTH  = 8;

  typedef struct packed {
    logic                 packet_valid;
    logic [PC_WIDTH-1:0]  pc;
    logic [OP_WIDTH-1:0]  opcode;
    logic [PRF_WIDTH-1:0] dest_prn;
    logic [PRF_WIDTH-1:0] src1_prn;
    logic [PRF_WIDTH-1:0] src2_prn;
  } issue_packet_t;

  localparam int unsigned ISSUE_PACKET = $bits(issue_packet_t);
endpackage

// rs_issue_select: per-FU oldest-first select over the reservation-station
// entries, with same-cycle grant/wake-up broadcast and registered FU packets.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pipe_flush      squash all selection state
//   rs_wake_up      NUM_RS x ISSUE_WIDTH ready requests (one FU per entry)
//   rs_age          NUM_RS x (ROB_WIDTH+1) ROB index with wrap bit
//   rs_issue_pkt    NUM_RS x ISSUE_PACKET entry packets
//   rob_head        oldest ROB index with wrap bit
//   fu_ready        per-FU accept
//   issue_en        per-entry grant (combinational)
//   issue_valid     per-FU grant (combinational)
//   issue_dest_prn  per-FU winner dest PRN, 0 when idle (combinational)
//   fu_issue_pkt    per-FU registered packet
//   div_busy        divider occupied
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int unsigned NUM_RS      = 8,
  parameter int unsigned ISSUE_WIDTH = 7,
  parameter int unsigned ROB_WIDTH   = 5,
  parameter int unsigned DIV_FU_ID   = 5,
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pipe_flush,
  input  logic [NUM_RS*ISSUE_WIDTH-1:0]       rs_wake_up,
  input  logic [NUM_RS*(ROB_WIDTH+1)-1:0]     rs_age,
  input  logic [NUM_RS*ISSUE_PACKET-1:0]      rs_issue_pkt,
  input  logic [ROB_WIDTH:0]                  rob_head,
  input  logic [ISSUE_WIDTH-1:0]              fu_ready,
  output logic [NUM_RS-1:0]                   issue_en,
  output logic [ISSUE_WIDTH-1:0]              issue_valid,
  output logic [ISSUE_WIDTH*PRF_WIDTH-1:0]    issue_dest_prn,
  output logic [ISSUE_WIDTH*ISSUE_PACKET-1:0] fu_issue_pkt,
  output logic                                div_busy
);

  localparam int unsigned AGE_W = ROB_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);
  localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [AGE_W-1:0]   rel_age   [NUM_RS];
  issue_packet_t      ent_pkt   [NUM_RS];
  logic [AGE_W-1:0]   best_age  [ISSUE_WIDTH];
  logic [IDX_W-1:0]   win_idx   [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] fu_open;
  logic [ISSUE_WIDTH-1:0] has_win;
  issue_packet_t      win_pkt   [ISSUE_WIDTH];
  issue_packet_t      fu_pkt_q  [ISSUE_WIDTH];
  logic [CNT_W-1:0]   div_cnt;
  logic               div_grant;

  // Age relative to the ROB head; modular subtraction handles the wrap bit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rel_age[i] = AGE_W'(rs_age[i*AGE_W +: AGE_W] - rob_head);
      ent_pkt[i] = issue_packet_t'(rs_issue_pkt[i*ISSUE_PACKET +: ISSUE_PACKET]);
    end
  end

  // An FU can take a grant only when ready, not flushing, and (divider) idle.
  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      fu_open[k] = fu_ready[k] && !pipe_flush && !((k == DIV_FU_ID) && div_busy);
    end
  end

  // Oldest-first scan; strict compare keeps the lowest index on equal age.
  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      has_win[k]  = 1'b0;
      win_idx[k]  = '0;
      best_age[k] = '0;
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (fu_open[k] && rs_wake_up[i*ISSUE_WIDTH + k] &&
            (!has_win[k] || (rel_age[i] < best_age[k]))) begin
          has_win[k]  = 1'b1;
          win_idx[k]  = IDX_W'(i);
          best_age[k] = rel_age[i];
        end
      end
    end
  end

  // Grant fan-out to entries and speculative wake-up broadcast.
  always_comb begin
    issue_en       = '0;
    issue_valid    = has_win;
    issue_dest_prn = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      win_pkt[k] = ent_pkt[win_idx[k]];
      if (has_win[k]) begin
        issue_en[win_idx[k]]                     = 1'b1;
        issue_dest_prn[k*PRF_WIDTH +: PRF_WIDTH] = win_pkt[k].dest_prn;
      end
    end
  end

  assign div_grant = has_win[DIV_FU_ID];

  // FU packet registers; idle FUs drop valid but keep the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        fu_pkt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        if (has_win[k] && !pipe_flush) begin
          fu_pkt_q[k]              <= win_pkt[k];
          fu_pkt_q[k].packet_valid <= 1'b1;
        end else begin
          fu_pkt_q[k].packet_valid <= 1'b0;
        end
      end
    end
  end

  // Divider occupancy: busy stays high while the counter is above 1 so that
  // the next grant lands exactly DIV_LATENCY cycles after the previous one.
  always_ff @(posedge clk) begin
    if (rst || pipe_flush) begin
      div_cnt  <= '0;
      div_busy <= 1'b0;
    end else if (div_grant) begin
      div_cnt  <= CNT_W'(DIV_LATENCY - 1);
      div_busy <= 1'b1;
    end else if (div_cnt != '0) begin
      div_cnt  <= div_cnt - CNT_W'(1);
      div_busy <= (div_cnt > CNT_W'(1));
    end else begin
      div_busy <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      fu_issue_pkt[k*ISSUE_PACKET +: ISSUE_PACKET] = fu_pkt_q[k];
    end
  end

endmodule
